ddr_burst_arbiter: RTL and testbench

Two-client round-robin arbiter in front of the DDR burst controller. It shares that controller's single burst port between the instruction-fetch client (client 0) and the data load/store client (client 1). One burst is in flight at a time. The arbiter latches the winning client's command, issues it downstream, routes data beats and the finish pulse back to the owner, then releases the port.

---
 rtl/ddr_burst_arbiter_if.sv | 52 +++++
 rtl/ddr_burst_arbiter.sv | 144 ++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_burst_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle between the two clients, the arbiter and the DDR burst controller.
// The arbiter uses the slave view; clients and the controller drive the master view.
interface ddr_burst_arbiter_if #(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28
);
    // client side
    logic [1:0]                  c_rd_req;
    logic [1:0]                  c_wr_req;
    logic [19:0]                 c_len;
    logic [2*DDR_ADDR_WIDTH-1:0] c_addr;
    logic [2*DDR_DATA_WIDTH-1:0] c_wr_data;
    logic [1:0]                  c_rd_valid;
    logic [1:0]                  c_wr_data_req;
    logic [DDR_DATA_WIDTH-1:0]   c_rd_data;
    logic [1:0]                  c_finish;
    logic [1:0]                  c_err;
    logic                        busy;
    // controller side
    logic                        ddr_ready;
    logic                        rd_burst_req;
    logic                        wr_burst_req;
    logic [9:0]                  rd_burst_len;
    logic [9:0]                  wr_burst_len;
    logic [DDR_ADDR_WIDTH-1:0]   rd_burst_addr;
    logic [DDR_ADDR_WIDTH-1:0]   wr_burst_addr;
    logic                        rd_burst_data_valid;
    logic                        wr_burst_data_req;
    logic                        rd_burst_finish;
    logic                        wr_burst_finish;
    logic [DDR_DATA_WIDTH-1:0]   rd_burst_data;
    logic [DDR_DATA_WIDTH-1:0]   wr_burst_data;

    modport slave (
        input  c_rd_req, c_wr_req, c_len, c_addr, c_wr_data,
        input  ddr_ready, rd_burst_data_valid, wr_burst_data_req,
        input  rd_burst_finish, wr_burst_finish, rd_burst_data,
        output c_rd_valid, c_wr_data_req, c_rd_data, c_finish, c_err, busy,
        output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
        output rd_burst_addr, wr_burst_addr, wr_burst_data
    );

    modport master (
        output c_rd_req, c_wr_req, c_len, c_addr, c_wr_data,
        output ddr_ready, rd_burst_data_valid, wr_burst_data_req,
        output rd_burst_finish, wr_burst_finish, rd_burst_data,
        input  c_rd_valid, c_wr_data_req, c_rd_data, c_finish, c_err, busy,
        input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
        input  rd_burst_addr, wr_burst_addr, wr_burst_data
    );
endinterface

// File: rtl/ddr_burst_arbiter.sv
`timescale 1ns/1ps
// Two-client round-robin arbiter sharing one DDR burst port.
// One burst in flight; the owner's command is latched on grant and the
// controller's beats and finish are routed back to the owner only.
module ddr_burst_arbiter #(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28
) (
    input  logic               clk,
    input  logic               rst,
    ddr_burst_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      grant_q, grant_d;
    logic                      op_wr_q, op_wr_d;
    logic [9:0]                len_q, len_d;
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [9:0]                beat_cnt_q, beat_cnt_d;
    logic                      rd_req_q, rd_req_d;
    logic                      wr_req_q, wr_req_d;
    logic [1:0]                err_q, err_d;

    logic [1:0] req_vec;
    logic       pick;
    logic       rd_beat;
    logic       wr_beat;
    logic [9:0] beat_total;
    logic       fin_match;
    logic       done;
    logic [9:0] pick_len;

    assign req_vec    = bus.c_rd_req | bus.c_wr_req;
    // On a tie the client that did not win last time gets the port.
    assign pick       = (req_vec == 2'b11) ? ~last_grant_q : req_vec[1];
    assign pick_len   = pick ? bus.c_len[19:10] : bus.c_len[9:0];
    assign rd_beat    = (state_q == WAIT) && bus.rd_burst_data_valid;
    assign wr_beat    = (state_q == WAIT) && bus.wr_burst_data_req;
    assign beat_total = beat_cnt_q + {9'd0, rd_beat} + {9'd0, wr_beat};
    assign fin_match  = op_wr_q ? bus.wr_burst_finish : bus.rd_burst_finish;
    assign done       = (state_q == DONE);

    // Next-state logic for the grant / issue / wait / done sequence.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_wr_d      = op_wr_q;
        len_d        = len_q;
        addr_d       = addr_q;
        beat_cnt_d   = beat_cnt_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    op_wr_d      = ~bus.c_rd_req[pick];
                    len_d        = pick_len;
                    addr_d       = pick ? bus.c_addr[2*DDR_ADDR_WIDTH-1:DDR_ADDR_WIDTH]
                                        : bus.c_addr[DDR_ADDR_WIDTH-1:0];
                    beat_cnt_d   = 10'd0;
                    if (pick_len == 10'd0) begin
                        // Empty burst: nothing goes downstream; one settling
                        // cycle in WAIT puts c_finish two cycles after the request.
                        state_d = WAIT;
                    end else begin
                        rd_req_d = bus.c_rd_req[pick];
                        wr_req_d = ~bus.c_rd_req[pick];
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.ddr_ready) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                beat_cnt_d = beat_total;
                if (len_q == 10'd0) begin
                    state_d = DONE;
                end else if (fin_match) begin
                    state_d = DONE;
                    if (beat_total != len_q) err_d[grant_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            len_q        <= '0;
            addr_q       <= '0;
            beat_cnt_q   <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_wr_q      <= op_wr_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            err_q        <= err_d;
        end
    end

    assign bus.busy          = (state_q != IDLE);
    assign bus.c_rd_valid    = {grant_q & rd_beat, ~grant_q & rd_beat};
    assign bus.c_wr_data_req = {grant_q & wr_beat, ~grant_q & wr_beat};
    assign bus.c_finish      = {grant_q & done, ~grant_q & done};
    assign bus.c_err         = err_q;
    assign bus.c_rd_data     = bus.rd_burst_data;
    assign bus.rd_burst_req  = rd_req_q;
    assign bus.wr_burst_req  = wr_req_q;
    assign bus.rd_burst_len  = len_q;
    assign bus.wr_burst_len  = len_q;
    assign bus.rd_burst_addr = addr_q;
    assign bus.wr_burst_addr = addr_q;
    assign bus.wr_burst_data = grant_q ? bus.c_wr_data[2*DDR_DATA_WIDTH-1:DDR_DATA_WIDTH]
                                       : bus.c_wr_data[DDR_DATA_WIDTH-1:0];
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for ddr_burst_arbiter: directed bursts push their expected
// downstream requests, beats and finish pulses; a negedge monitor pops them.
module tb_ddr_burst_arbiter;
    localparam int DW = 128;
    localparam int AW = 28;
    localparam logic [1:0] K_REQ  = 2'd0;
    localparam logic [1:0] K_BEAT = 2'd1;
    localparam logic [1:0] K_FIN  = 2'd2;

    typedef struct {
        string      name;
        int         cyc;
        logic [1:0] kind;
        logic       rd_req;
        logic       wr_req;
        logic [AW-1:0] addr;
        logic [9:0] len;
        logic [1:0] rdv;
        logic [1:0] wdr;
        logic [1:0] fin;
        logic [1:0] err;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0] exp_err = 2'b00;
    exp_t sb[$];
    exp_t mon_e;
    bit   ok;

    ddr_burst_arbiter_if #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW)) bus ();

    ddr_burst_arbiter #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int c, input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(c * 256 + i);
        return {4{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input int c_at, input logic [1:0] kind,
                        input logic rq, input logic wq, input logic [AW-1:0] addr,
                        input logic [9:0] len, input logic [1:0] rdv, input logic [1:0] wdr,
                        input logic [1:0] fin, input logic [1:0] err, input logic [DW-1:0] data);
        exp_t e;
        e.name = name; e.cyc = c_at; e.kind = kind; e.rd_req = rq; e.wr_req = wq;
        e.addr = addr; e.len = len; e.rdv = rdv; e.wdr = wdr; e.fin = fin;
        e.err = err; e.data = data;
        sb.push_back(e);
    endtask

    task automatic raise(input int c, input bit rd, input bit wr,
                         input logic [9:0] len, input logic [AW-1:0] addr);
        bus.c_rd_req[c]        = rd;
        bus.c_wr_req[c]        = wr;
        bus.c_len[c*10 +: 10]  = len;
        bus.c_addr[c*AW +: AW] = addr;
    endtask

    task automatic drop(input int c);
        bus.c_rd_req[c] = 1'b0;
        bus.c_wr_req[c] = 1'b0;
    endtask

    // Called in the IDLE cycle where client c is expected to win. Plays the
    // controller, queues every expected output, and returns in the next IDLE cycle.
    task automatic serve(input int c, input bit op_rd, input logic [9:0] len,
                         input logic [AW-1:0] addr, input int beats, input int stall,
                         input bit poke_other, input string tag);
        int t;
        logic [1:0] cm;
        t  = cyc;
        cm = 2'(1 << c);
        if (len == 10'd0) begin
            push({tag, "_fin"}, t + 2, K_FIN, 0, 0, '0, '0, 2'b00, 2'b00, cm, exp_err, '0);
            tick(); tick();
            drop(c);
            tick();
            return;
        end
        bus.ddr_ready = (stall == 0);
        for (int k = 0; k <= stall; k++)
            push({tag, "_req"}, t + 1 + k, K_REQ, op_rd, !op_rd, addr, len,
                 2'b00, 2'b00, 2'b00, 2'b00, '0);
        tick();
        for (int k = 1; k <= stall; k++) begin
            tick();
            bus.ddr_ready = (k == stall);
        end
        tick();
        for (int i = 0; i < beats; i++) begin
            bus.rd_burst_data_valid = op_rd;
            bus.wr_burst_data_req   = !op_rd;
            bus.rd_burst_data       = pat(c, i);
            bus.c_wr_data[c*DW +: DW]       = pat(c, i);
            bus.c_wr_data[(1-c)*DW +: DW]   = ~pat(c, i);
            if (poke_other && i == 1) raise(1 - c, 1, 0, 10'd3, 28'h300);
            push({tag, "_beat"}, cyc, K_BEAT, 0, 0, '0, '0,
                 op_rd ? cm : 2'b00, op_rd ? 2'b00 : cm, 2'b00, 2'b00, pat(c, i));
            tick();
        end
        bus.rd_burst_data_valid = 1'b0;
        bus.wr_burst_data_req   = 1'b0;
        bus.rd_burst_finish     = op_rd;
        bus.wr_burst_finish     = !op_rd;
        if (beats != int'(len)) exp_err[c] = 1'b1;
        push({tag, "_fin"}, cyc + 1, K_FIN, 0, 0, '0, '0, 2'b00, 2'b00, cm, exp_err, '0);
        tick();
        bus.rd_burst_finish = 1'b0;
        bus.wr_burst_finish = 1'b0;
        drop(c);
        tick();
    endtask

    // Monitor: any cycle the DUT presents an output event must match the queue head.
    always @(negedge clk) begin
        if (bus.rd_burst_req || bus.wr_burst_req || bus.c_rd_valid != 2'b00 ||
            bus.c_wr_data_req != 2'b00 || bus.c_finish != 2'b00) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected @%0d: rq=%b wq=%b rv=%b wd=%b fin=%b", cyc,
                         bus.rd_burst_req, bus.wr_burst_req, bus.c_rd_valid,
                         bus.c_wr_data_req, bus.c_finish);
            end else begin
                mon_e = sb.pop_front();
                ok = (cyc == mon_e.cyc) && (bus.rd_burst_req === mon_e.rd_req) &&
                     (bus.wr_burst_req === mon_e.wr_req) && (bus.c_rd_valid === mon_e.rdv) &&
                     (bus.c_wr_data_req === mon_e.wdr) && (bus.c_finish === mon_e.fin);
                case (mon_e.kind)
                    K_REQ: ok &= mon_e.rd_req ?
                        (bus.rd_burst_addr === mon_e.addr && bus.rd_burst_len === mon_e.len) :
                        (bus.wr_burst_addr === mon_e.addr && bus.wr_burst_len === mon_e.len);
                    K_BEAT: ok &= ((mon_e.rdv != 2'b00) ? bus.c_rd_data : bus.wr_burst_data) === mon_e.data;
                    default: ok &= (bus.c_err === mon_e.err);
                endcase
                if (!ok) begin
                    n_errors++;
                    $display("FAIL %s @%0d (want @%0d): got rq=%b wq=%b rv=%b wd=%b fin=%b err=%b addr=%h len=%0d rdata=%h wdata=%h; want rq=%b wq=%b rv=%b wd=%b fin=%b err=%b addr=%h len=%0d data=%h",
                             mon_e.name, cyc, mon_e.cyc, bus.rd_burst_req, bus.wr_burst_req,
                             bus.c_rd_valid, bus.c_wr_data_req, bus.c_finish, bus.c_err,
                             bus.rd_burst_req ? bus.rd_burst_addr : bus.wr_burst_addr,
                             bus.rd_burst_len, bus.c_rd_data, bus.wr_burst_data,
                             mon_e.rd_req, mon_e.wr_req, mon_e.rdv, mon_e.wdr, mon_e.fin,
                             mon_e.err, mon_e.addr, mon_e.len, mon_e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.c_rd_req = '0; bus.c_wr_req = '0; bus.c_len = '0; bus.c_addr = '0;
        bus.c_wr_data = '0; bus.ddr_ready = 1'b1; bus.rd_burst_data_valid = 1'b0;
        bus.wr_burst_data_req = 1'b0; bus.rd_burst_finish = 1'b0;
        bus.wr_burst_finish = 1'b0; bus.rd_burst_data = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_busy",   64'(bus.busy), 64'd0);
        check("rst_rdreq",  64'(bus.rd_burst_req), 64'd0);
        check("rst_wrreq",  64'(bus.wr_burst_req), 64'd0);
        check("rst_finish", 64'(bus.c_finish), 64'd0);
        check("rst_err",    64'(bus.c_err), 64'd0);
        check("rst_addr",   64'(bus.rd_burst_addr), 64'd0);
        check("rst_len",    64'(bus.wr_burst_len), 64'd0);
        check("rst_rdv",    64'(bus.c_rd_valid), 64'd0);

        // Tie from reset: client 0, then 1; tie again goes back to client 0.
        raise(0, 0, 1, 10'd2, 28'h200);
        raise(1, 0, 1, 10'd2, 28'h280);
        serve(0, 0, 10'd2, 28'h200, 2, 0, 0, "tie_a0");
        serve(1, 0, 10'd2, 28'h280, 2, 0, 0, "tie_a1");
        raise(0, 0, 1, 10'd1, 28'h210);
        raise(1, 0, 1, 10'd1, 28'h290);
        serve(0, 0, 10'd1, 28'h210, 1, 0, 0, "tie_b0");
        serve(1, 0, 10'd1, 28'h290, 1, 0, 0, "tie_b1");

        // Plain client 0 read.
        raise(0, 1, 0, 10'd4, 28'h100);
        serve(0, 1, 10'd4, 28'h100, 4, 0, 0, "rd0");

        // Client 0 raises mid-burst of client 1; served 3 cycles after finish.
        raise(1, 1, 0, 10'd4, 28'h180);
        serve(1, 1, 10'd4, 28'h180, 4, 0, 1, "rd1");
        serve(0, 1, 10'd3, 28'h300, 3, 0, 0, "late0");

        // Read and write together: read wins.
        raise(0, 1, 1, 10'd2, 28'h400);
        serve(0, 1, 10'd2, 28'h400, 2, 0, 0, "rdwr");

        // Zero-length burst on client 1.
        raise(1, 1, 0, 10'd0, 28'h500);
        serve(1, 1, 10'd0, 28'h500, 0, 0, 0, "len0");

        // Short burst raises c_err[1]; it stays set across the next burst.
        raise(1, 1, 0, 10'd4, 28'h600);
        serve(1, 1, 10'd4, 28'h600, 3, 0, 0, "short");
        raise(1, 0, 1, 10'd1, 28'h640);
        serve(1, 0, 10'd1, 28'h640, 1, 0, 0, "sticky");

        // ddr_ready low for 5 cycles in ISSUE.
        raise(0, 0, 1, 10'd1, 28'h700);
        serve(0, 0, 10'd1, 28'h700, 1, 5, 0, "stall");

        // Reset in the middle of a read burst.
        raise(0, 1, 0, 10'd4, 28'h800);
        t = cyc;
        push("rstw_req", t + 1, K_REQ, 1, 0, 28'h800, 10'd4, 2'b00, 2'b00, 2'b00, 2'b00, '0);
        tick(); tick();
        bus.rd_burst_data_valid = 1'b1;
        bus.rd_burst_data       = pat(0, 9);
        push("rstw_beat", cyc, K_BEAT, 0, 0, '0, '0, 2'b01, 2'b00, 2'b00, 2'b00, pat(0, 9));
        rst = 1'b1;
        drop(0);
        tick();
        bus.rd_burst_data_valid = 1'b0;
        rst = 1'b0;
        exp_err = 2'b00;
        #1;
        check("rstw_busy",  64'(bus.busy), 64'd0);
        check("rstw_rdreq", 64'(bus.rd_burst_req), 64'd0);
        check("rstw_rdv",   64'(bus.c_rd_valid), 64'd0);
        check("rstw_fin",   64'(bus.c_finish), 64'd0);
        check("rstw_err",   64'(bus.c_err), 64'd0);
        check("rstw_addr",  64'(bus.rd_burst_addr), 64'd0);
        check("rstw_len",   64'(bus.rd_burst_len), 64'd0);

        // last_grant restored by reset: client 0 wins the tie again.
        raise(0, 1, 0, 10'd1, 28'h900);
        raise(1, 1, 0, 10'd1, 28'h980);
        serve(0, 1, 10'd1, 28'h900, 1, 0, 0, "post_0");
        serve(1, 1, 10'd1, 28'h980, 1, 0, 0, "post_1");

        tick(); tick(); tick();
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
